sync_debounce: RTL and testbench

//   Input-conditioning stage that sits directly upstream of the d_ff storage element.
//   It takes an asynchronous, possibly bouncing level (button, strap, external pin) and

---
 rtl/sync_debounce.sv | 102 ++++++++++
 tb/tb_sync_debounce.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// sync_debounce: synchronizes an asynchronous level into clk, debounces it with a
// consecutive-sample counter, and presents a clean level, edge pulses and an abort count.
module sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_async,
    output logic                q,
    output logic                q_not,
    output logic                rise,
    output logic                fall,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    // Counter needs at least one bit even when a single sample qualifies a change.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } phase_t;

    logic [SYNC_STAGES-1:0] chain;
    logic                   s;
    phase_t                 phase;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                q_next;
    logic                rise_next;
    logic                fall_next;
    logic [GLITCH_W-1:0] glitch_next;

    // Plain flop chain; nothing sits between the stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d_async};
        end
    end

    assign s     = chain[SYNC_STAGES-1];
    assign phase = (s != q) ? QUALIFY : STABLE;

    // Debounce state register: accepted level, run counter, pulses, abort count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q          <= 1'b0;
            cnt        <= '0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            q          <= q_next;
            cnt        <= cnt_next;
            rise       <= rise_next;
            fall       <= fall_next;
            glitch_cnt <= glitch_next;
        end
    end

    // Next state: count differing samples, accept on the last one, count aborted runs.
    always_comb begin
        q_next      = q;
        cnt_next    = cnt;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        glitch_next = glitch_cnt;
        unique case (phase)
            QUALIFY: begin
                if (cnt == CNT_LAST) begin
                    q_next    = s;
                    cnt_next  = '0;
                    rise_next = s;
                    fall_next = ~s;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STABLE: begin
                // A run that ended before acceptance is a glitch; the count saturates.
                if ((cnt != '0) && (glitch_cnt != '1)) begin
                    glitch_next = glitch_cnt + GLITCH_W'(1);
                end
                cnt_next = '0;
            end
            default: begin
                cnt_next = '0;
            end
        endcase
    end

    assign q_not = ~q;
    assign busy  = (phase == QUALIFY);

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed stimulus pushes expected pulses (kind and edge number)
// into a queue; a monitor pops and compares whenever the DUT emits rise or fall.
`timescale 1ns / 1ps
module tb_sync_debounce;

    localparam int unsigned GW = 8;

    logic          clk;
    logic          reset;
    logic          d_async;
    logic          q;
    logic          q_not;
    logic          rise;
    logic          fall;
    logic          busy;
    logic [GW-1:0] glitch_cnt;

    typedef struct {
        bit is_rise;
        int at_edge;
    } ev_t;

    ev_t exp_q[$];
    int  cyc    = 0;
    int  errors = 0;
    int  checks = 0;

    sync_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .GLITCH_W       (GW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_async   (d_async),
        .q         (q),
        .q_not     (q_not),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy),
        .glitch_cnt(glitch_cnt)
    );

    // 1 us clock period.
    initial clk = 1'b0;
    always #500 clk = ~clk;

    // Rising-edge counter used to timestamp pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit is_rise, input int at_edge);
        ev_t e;
        e.is_rise = is_rise;
        e.at_edge = at_edge;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_q"}, int'(q), 0);
        chk({tag, "_q_not"}, int'(q_not), 1);
        chk({tag, "_rise"}, int'(rise), 0);
        chk({tag, "_fall"}, int'(fall), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_glitch"}, int'(glitch_cnt), 0);
    endtask

    // Monitor: every emitted pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && (rise || fall)) begin
            chk("rise_fall_exclusive", int'(rise & fall), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(rise) * 2 + int'(fall), 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_kind_rise", int'(rise), int'(e.is_rise));
                chk("pulse_edge", cyc, e.at_edge);
                chk("pulse_q_level", int'(q), int'(e.is_rise));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        reset   = 1'b0;
        d_async = 1'b1;

        // Reset held with d_async high: everything stays cleared.
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk_reset_state("in_reset");
        end

        // Release with input low, then a clean 0->1: rise on edge 6, busy on edges 2..5.
        d_async = 1'b0;
        reset   = 1'b1;
        tick(3);
        chk("idle_q", int'(q), 0);
        d_async = 1'b1;
        t0 = cyc;
        push(1'b1, t0 + 6);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            chk("rise_busy", int'(busy), (k >= 2 && k <= 5) ? 1 : 0);
            chk("rise_q", int'(q), (k >= 6) ? 1 : 0);
        end
        chk("rise_q_not", int'(q_not), 0);
        chk("rise_glitch", int'(glitch_cnt), 0);

        // Clean 1->0: fall on edge 6.
        d_async = 1'b0;
        t0 = cyc;
        push(1'b0, t0 + 6);
        tick(8);
        chk("fall_q", int'(q), 0);
        chk("fall_q_not", int'(q_not), 1);

        // High for two cycles only: aborted, counted once.
        d_async = 1'b1;
        tick(2);
        d_async = 1'b0;
        tick(8);
        chk("short_q", int'(q), 0);
        chk("short_glitch", int'(glitch_cnt), 1);

        // Bounce 1,0,1,0 then stable 1: two aborts, single rise on edge 10.
        t0 = cyc;
        push(1'b1, t0 + 10);
        d_async = 1'b1; tick(1);
        d_async = 1'b0; tick(1);
        d_async = 1'b1; tick(1);
        d_async = 1'b0; tick(1);
        d_async = 1'b1;
        tick(8);
        chk("bounce_q", int'(q), 1);
        chk("bounce_glitch", int'(glitch_cnt), 3);

        // Drop to 0, reset mid-qualification after edge 4: no fall, all cleared.
        d_async = 1'b0;
        tick(4);
        chk("midq_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk_reset_state("midq_reset");
        d_async = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk_reset_state("midq_hold");
        end

        // Release with d_async held high: full-latency rise on edge 6.
        reset = 1'b1;
        t0 = cyc;
        push(1'b1, t0 + 6);
        tick(5);
        chk("requal_q_edge5", int'(q), 0);
        tick(3);
        chk("requal_q", int'(q), 1);
        chk("requal_glitch", int'(glitch_cnt), 0);

        // One-cycle low glitches against q=1; counter saturates at 255.
        for (int g = 0; g < 100; g++) begin
            d_async = 1'b0; tick(1);
            d_async = 1'b1; tick(2);
        end
        tick(2);
        chk("glitch_100", int'(glitch_cnt), 100);
        for (int g = 0; g < 155; g++) begin
            d_async = 1'b0; tick(1);
            d_async = 1'b1; tick(2);
        end
        tick(2);
        chk("glitch_255", int'(glitch_cnt), 255);
        for (int g = 0; g < 45; g++) begin
            d_async = 1'b0; tick(1);
            d_async = 1'b1; tick(2);
        end
        tick(2);
        chk("glitch_sat", int'(glitch_cnt), 255);
        chk("glitch_q", int'(q), 1);

        tick(2);
        chk("pending_pulses", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
